// File: rtl/panel_chain_driver.sv
// Serial driver for a daisy-chained RGB LED driver chain: shifts NUM_DRIVERS words per
// colour MSB-first on three lockstep data lines with a shared shift clock, then latches.
module panel_chain_driver #(
    parameter int WIDTH        = 16,
    parameter int NUM_DRIVERS  = 4,
    parameter int BRIGHT_WIDTH = 8,
    localparam int ADDR_W      = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [1:0]              wr_color,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    bri_wr_en,
    input  logic [BRIGHT_WIDTH-1:0] bri_data,
    input  logic                    start,
    input  logic                    mode,
    output logic                    serial_clk,
    output logic                    serial_data_out_red,
    output logic                    serial_data_out_green,
    output logic                    serial_data_out_blue,
    output logic                    latch,
    output logic                    busy,
    output logic                    done
);

    localparam int                CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ADDR_W-1:0] LP_LAST     = ADDR_W'(NUM_DRIVERS - 1);
    localparam logic [ADDR_W:0]   LP_ND       = (ADDR_W + 1)'(NUM_DRIVERS);
    localparam logic [CNT_W-1:0]  LP_BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    logic [WIDTH-1:0]        r_red   [NUM_DRIVERS];
    logic [WIDTH-1:0]        r_green [NUM_DRIVERS];
    logic [WIDTH-1:0]        r_blue  [NUM_DRIVERS];
    logic [BRIGHT_WIDTH-1:0] r_bright;

    state_t                  r_state;
    logic                    r_mode;
    logic [ADDR_W-1:0]       r_idx;
    logic [CNT_W-1:0]        r_bit;
    logic [WIDTH-1:0]        r_sh_red;
    logic [WIDTH-1:0]        r_sh_green;
    logic [WIDTH-1:0]        r_sh_blue;
    logic                    r_sclk;
    logic                    r_sd_red;
    logic                    r_sd_green;
    logic                    r_sd_blue;
    logic                    r_latch;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_wr_ok;
    logic [WIDTH-1:0]        w_ld_red;
    logic [WIDTH-1:0]        w_ld_green;
    logic [WIDTH-1:0]        w_ld_blue;
    logic [WIDTH-1:0]        w_nxt_red;
    logic [WIDTH-1:0]        w_nxt_green;
    logic [WIDTH-1:0]        w_nxt_blue;

    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < LP_ND);
    assign w_nxt_red   = r_sh_red << 1;
    assign w_nxt_green = r_sh_green << 1;
    assign w_nxt_blue  = r_sh_blue << 1;

    // Colour arrays and brightness register; writable at any time, even mid-transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DRIVERS; i++) begin
                r_red[i]   <= {WIDTH{1'b0}};
                r_green[i] <= {WIDTH{1'b0}};
                r_blue[i]  <= {WIDTH{1'b0}};
            end
            r_bright <= {BRIGHT_WIDTH{1'b1}};
        end else begin
            if (w_wr_ok) begin
                case (wr_color)
                    2'd0:    r_red[wr_addr]   <= wr_data;
                    2'd1:    r_green[wr_addr] <= wr_data;
                    2'd2:    r_blue[wr_addr]  <= wr_data;
                    default: r_red[wr_addr]   <= r_red[wr_addr];
                endcase
            end
            if (bri_wr_en) begin
                r_bright <= bri_data;
            end
        end
    end

    // Word selected for the next LOAD: the stored LED word or the brightness broadcast.
    always_comb begin
        w_ld_red   = {WIDTH{1'b0}};
        w_ld_green = {WIDTH{1'b0}};
        w_ld_blue  = {WIDTH{1'b0}};
        if (r_mode) begin
            w_ld_red   = WIDTH'(r_bright);
            w_ld_green = WIDTH'(r_bright);
            w_ld_blue  = WIDTH'(r_bright);
        end else begin
            w_ld_red   = r_red[r_idx];
            w_ld_green = r_green[r_idx];
            w_ld_blue  = r_blue[r_idx];
        end
    end

    // Transfer sequencer; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_idx      <= LP_LAST;
            r_bit      <= {CNT_W{1'b0}};
            r_sh_red   <= {WIDTH{1'b0}};
            r_sh_green <= {WIDTH{1'b0}};
            r_sh_blue  <= {WIDTH{1'b0}};
            r_sclk     <= 1'b0;
            r_sd_red   <= 1'b0;
            r_sd_green <= 1'b0;
            r_sd_blue  <= 1'b0;
            r_latch    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_latch <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_mode  <= mode;
                        r_idx   <= LP_LAST;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_sh_red   <= w_ld_red;
                    r_sh_green <= w_ld_green;
                    r_sh_blue  <= w_ld_blue;
                    r_sd_red   <= w_ld_red[WIDTH-1];
                    r_sd_green <= w_ld_green[WIDTH-1];
                    r_sd_blue  <= w_ld_blue[WIDTH-1];
                    r_bit      <= LP_BIT_LAST;
                    r_sclk     <= 1'b0;
                    r_state    <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    r_sclk  <= 1'b1;
                    r_state <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    r_sh_red   <= w_nxt_red;
                    r_sh_green <= w_nxt_green;
                    r_sh_blue  <= w_nxt_blue;
                    r_sclk     <= 1'b0;
                    if (r_bit != {CNT_W{1'b0}}) begin
                        r_bit      <= r_bit - CNT_W'(1);
                        r_sd_red   <= w_nxt_red[WIDTH-1];
                        r_sd_green <= w_nxt_green[WIDTH-1];
                        r_sd_blue  <= w_nxt_blue[WIDTH-1];
                        r_state    <= ST_SHIFT_LO;
                    end else begin
                        r_sd_red   <= 1'b0;
                        r_sd_green <= 1'b0;
                        r_sd_blue  <= 1'b0;
                        if (r_idx != {ADDR_W{1'b0}}) begin
                            r_idx   <= r_idx - ADDR_W'(1);
                            r_state <= ST_LOAD;
                        end else begin
                            r_latch <= 1'b1;
                            r_state <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sclk     <= 1'b0;
                    r_sd_red   <= 1'b0;
                    r_sd_green <= 1'b0;
                    r_sd_blue  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign serial_clk            = r_sclk;
    assign serial_data_out_red   = r_sd_red;
    assign serial_data_out_green = r_sd_green;
    assign serial_data_out_blue  = r_sd_blue;
    assign latch                 = r_latch;
    assign busy                  = r_busy;
    assign done                  = r_done;

endmodule

// File: tb/tb_panel_chain_driver.sv
// Bench for panel_chain_driver: randomized transfers checked against a word-level model
// of the colour arrays, brightness and per-word load timing.
module tb_panel_chain_driver;

    localparam int ND   = 3;
    localparam int W    = 16;
    localparam int BW   = 8;
    localparam int WL   = 1 + 2 * W;
    localparam int XLEN = ND * WL;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          wr_en     = 1'b0;
    logic [1:0]    wr_color  = 2'd0;
    logic [1:0]    wr_addr   = 2'd0;
    logic [W-1:0]  wr_data   = 16'h0000;
    logic          bri_wr_en = 1'b0;
    logic [BW-1:0] bri_data  = 8'h00;
    logic          start     = 1'b0;
    logic          mode      = 1'b0;
    logic          serial_clk;
    logic          serial_data_out_red;
    logic          serial_data_out_green;
    logic          serial_data_out_blue;
    logic          latch;
    logic          busy;
    logic          done;
    logic [2:0]    w_sd;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  m_arr [3][ND];
    logic [BW-1:0] m_bri;

    always #5 clk = ~clk;

    assign w_sd = {serial_data_out_blue, serial_data_out_green, serial_data_out_red};

    panel_chain_driver #(.WIDTH(W), .NUM_DRIVERS(ND), .BRIGHT_WIDTH(BW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .wr_en                (wr_en),
        .wr_color             (wr_color),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .bri_wr_en            (bri_wr_en),
        .bri_data             (bri_data),
        .start                (start),
        .mode                 (mode),
        .serial_clk           (serial_clk),
        .serial_data_out_red  (serial_data_out_red),
        .serial_data_out_green(serial_data_out_green),
        .serial_data_out_blue (serial_data_out_blue),
        .latch                (latch),
        .busy                 (busy),
        .done                 (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < ND; i++) begin
                m_arr[c][i] = 16'h0000;
            end
        end
        m_bri = 8'hff;
    endtask

    task automatic write_word(input logic [1:0] col, input logic [1:0] addr, input logic [W-1:0] dat);
        wr_en = 1'b1; wr_color = col; wr_addr = addr; wr_data = dat;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (col < 2'd3 && int'(addr) < ND) m_arr[col][addr] = dat;
    endtask

    task automatic fill_random();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < ND; i++) begin
                write_word(2'(c), 2'(i), 16'($urandom));
            end
        end
    endtask

    // One full transfer with optional single LED write, brightness write and spurious start.
    task automatic run_xfer(input string nm, input logic md, input int wcyc, input logic [1:0] wcol,
                            input logic [1:0] waddr, input logic [W-1:0] wdat, input int bcyc,
                            input logic [BW-1:0] bdat, input int scyc);
        logic [ND*W-1:0] exp_s [3];
        logic [ND*W-1:0] got_s [3];
        logic [W-1:0]    v;
        logic [BW-1:0]   b;
        logic            prev;
        int nbits, nlatch, lat_cyc, ndone, done_cyc, busy_err, zero_err, idx, ld;
        for (int c = 0; c < 3; c++) begin
            exp_s[c] = '0;
            got_s[c] = '0;
        end
        for (int k = 0; k < ND; k++) begin
            idx = ND - 1 - k;
            ld  = k * WL;
            for (int c = 0; c < 3; c++) begin
                if (md == 1'b0) begin
                    v = m_arr[c][idx];
                    if (wcyc >= 0 && wcyc < ld && int'(wcol) == c && int'(waddr) == idx) v = wdat;
                end else begin
                    b = (bcyc >= 0 && bcyc < ld) ? bdat : m_bri;
                    v = {8'h00, b};
                end
                exp_s[c] = {exp_s[c][ND*W-W-1:0], v};
            end
        end
        nbits = 0; nlatch = 0; lat_cyc = -1; ndone = 0; done_cyc = -1; busy_err = 0; zero_err = 0;
        prev = 1'b0;
        start = 1'b1; mode = md;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_before_start got=%b exp=0", nm, busy);
        end
        @(posedge clk); #1;
        for (int cyc = 0; cyc < XLEN + 4; cyc++) begin
            start     = (cyc == scyc);
            mode      = 1'($urandom);
            wr_en     = (cyc == wcyc);
            wr_color  = wcol; wr_addr = waddr; wr_data = wdat;
            bri_wr_en = (cyc == bcyc);
            bri_data  = bdat;
            @(negedge clk);
            if (serial_clk === 1'b1 && prev === 1'b0) begin
                for (int c = 0; c < 3; c++) got_s[c] = {got_s[c][ND*W-2:0], w_sd[c]};
                nbits++;
            end
            if ((cyc >= XLEN || (cyc % WL) == 0) && ({serial_clk, w_sd} !== 4'b0000)) zero_err++;
            if (latch === 1'b1) begin nlatch++; lat_cyc = cyc; end
            if (done === 1'b1) begin ndone++; done_cyc = cyc; end
            if (busy !== ((cyc <= XLEN + 1) ? 1'b1 : 1'b0)) busy_err++;
            prev = serial_clk;
            @(posedge clk); #1;
        end
        start = 1'b0; wr_en = 1'b0; bri_wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (got_s[c] !== exp_s[c]) begin
                failures++;
                $display("FAIL %s stream_c%0d got=%h exp=%h", nm, c, got_s[c], exp_s[c]);
            end
        end
        checks++;
        if (nbits != ND * W) begin
            failures++;
            $display("FAIL %s bit_count got=%0d exp=%0d", nm, nbits, ND * W);
        end
        checks++;
        if (nlatch != 1 || lat_cyc != XLEN) begin
            failures++;
            $display("FAIL %s latch got=%0d@%0d exp=1@%0d", nm, nlatch, lat_cyc, XLEN);
        end
        checks++;
        if (ndone != 1 || done_cyc != XLEN + 1) begin
            failures++;
            $display("FAIL %s done got=%0d@%0d exp=1@%0d", nm, ndone, done_cyc, XLEN + 1);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy_profile got=%0d_bad_cycles exp=0", nm, busy_err);
        end
        checks++;
        if (zero_err != 0) begin
            failures++;
            $display("FAIL %s idle_lines got=%0d_nonzero_cycles exp=0", nm, zero_err);
        end
        if (wcyc >= 0 && wcol < 2'd3 && int'(waddr) < ND) m_arr[wcol][waddr] = wdat;
        if (bcyc >= 0) m_bri = bdat;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({serial_clk, w_sd, latch, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000", {serial_clk, w_sd, latch, busy, done});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        checks++;
        if ({serial_clk, w_sd, latch, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=0000000", {serial_clk, w_sd, latch, busy, done});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bright_default();
        run_xfer("bright_default", 1'b1, -1, 2'd0, 2'd0, 16'h0000, -1, 8'h00, -1);
    endtask

    task automatic test_directed();
        write_word(2'd0, 2'd2, 16'h1234);
        write_word(2'd0, 2'd1, 16'haaaa);
        write_word(2'd0, 2'd0, 16'h0f0f);
        write_word(2'd1, 2'd2, 16'h8001);
        write_word(2'd2, 2'd0, 16'hffff);
        run_xfer("directed", 1'b0, -1, 2'd0, 2'd0, 16'h0000, -1, 8'h00, -1);
    endtask

    task automatic test_mid_write();
        fill_random();
        run_xfer("mid_wr_later_word", 1'b0, 10, 2'd0, 2'd0, 16'hffff, -1, 8'h00, -1);
        run_xfer("mid_wr_current_word", 1'b0, 10, 2'd0, 2'd2, 16'h0bad, -1, 8'h00, -1);
        run_xfer("wr_same_cycle_load", 1'b0, WL, 2'd1, 2'd1, 16'h5a5a, -1, 8'h00, -1);
        run_xfer("wr_cycle_before_load", 1'b0, WL - 1, 2'd2, 2'd1, 16'hc3c3, -1, 8'h00, -1);
    endtask

    task automatic test_bri_mid();
        run_xfer("bri_mid", 1'b1, -1, 2'd0, 2'd0, 16'h0000, WL + 7, 8'h3c, -1);
    endtask

    task automatic test_start_ignored();
        run_xfer("start_ignored", 1'b0, -1, 2'd0, 2'd0, 16'h0000, -1, 8'h00, 20);
    endtask

    task automatic test_ignored_writes();
        write_word(2'd3, 2'd0, 16'hdead);
        write_word(2'd0, 2'd3, 16'hbeef);
        run_xfer("ignored_writes", 1'b0, -1, 2'd0, 2'd0, 16'h0000, -1, 8'h00, -1);
    endtask

    task automatic test_reset_mid();
        int n, nl, nd, nb;
        fill_random();
        start = 1'b1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(n >= 40 && serial_clk === 1'b1) && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL reset_mid_find_shift_hi got=timeout exp=serial_clk_high");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({serial_clk, w_sd, latch, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_async got=%b exp=0000000", {serial_clk, w_sd, latch, busy, done});
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        nl = 0; nd = 0; nb = 0;
        repeat (XLEN + 10) begin
            @(negedge clk);
            nl += int'(latch === 1'b1);
            nd += int'(done === 1'b1);
            nb += int'(busy !== 1'b0);
        end
        checks++;
        if (nl != 0 || nd != 0 || nb != 0) begin
            failures++;
            $display("FAIL reset_mid_abort got=latch%0d_done%0d_busy%0d exp=0_0_0", nl, nd, nb);
        end
        @(posedge clk); #1;
        run_xfer("after_reset_mid", 1'b0, -1, 2'd0, 2'd0, 16'h0000, -1, 8'h00, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            if (t % 2 == 0) fill_random();
            run_xfer("random", 1'($urandom), $urandom_range(0, XLEN - 1), 2'($urandom), 2'($urandom),
                     16'($urandom), $urandom_range(0, XLEN - 1), 8'($urandom), $urandom_range(1, XLEN));
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_bright_default();
        test_directed();
        test_mid_write();
        test_bri_mid();
        test_start_ignored();
        test_ignored_writes();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_chain_driver.md
PANEL_CHAIN_DRIVER -- requirements
Module: panel_chain_driver

Interface
REQ-001 Parameter WIDTH, default 16: bits per driver word; SHALL be >= BRIGHT_WIDTH.
REQ-002 Parameter NUM_DRIVERS, default 4: daisy-chained driver words per colour, >= 1.
REQ-003 Parameter BRIGHT_WIDTH, default 8: brightness register width.
REQ-004 Localparam ADDR_W = max(1, clog2(NUM_DRIVERS)).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  write one LED word this cycle.
REQ-008 wr_color  input  2  0 red, 1 green, 2 blue, 3 ignored.
REQ-009 wr_addr  input  ADDR_W  driver index; writes with wr_addr >= NUM_DRIVERS ignored.
REQ-010 wr_data  input  WIDTH  LED word.
REQ-011 bri_wr_en  input  1  load bri_data into brightness register.
REQ-012 bri_data  input  BRIGHT_WIDTH  brightness value.
REQ-013 start  input  1  request one chain transfer.
REQ-014 mode  input  1  sampled with start: 0 LED values, 1 brightness.
REQ-015 serial_clk  output  1  shift clock to driver chain.
REQ-016 serial_data_out_red / _green / _blue  output  1 each  serial data, MSB first.
REQ-017 latch  output  1  one-cycle latch pulse to chain.
REQ-018 busy  output  1  transfer in progress.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 Storage: three register arrays (red, green, blue) of NUM_DRIVERS x WIDTH; write on wr_en, effective next cycle.
REQ-021 Writes accepted at all times, including while busy; a write affects only words not yet loaded into the shift registers.
REQ-022 bri_wr_en writes are accepted at all times; the brightness value is sampled at each word load.
REQ-023 FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-024 IDLE: start=1 -> LOAD, latch mode, word index = NUM_DRIVERS-1; busy=1 from the next cycle.
REQ-025 start while not IDLE is ignored; mode is not re-sampled.
REQ-026 LOAD (1 cycle): each colour shift register <= array[index] (mode 0) or zero-extended brightness (mode 1, identical for all colours); bit counter = WIDTH-1; -> SHIFT_LO.
REQ-027 SHIFT_LO (1 cycle): serial_clk=0; serial data = shift register MSB; -> SHIFT_HI.
REQ-028 SHIFT_HI (1 cycle): serial_clk=1, data unchanged; at exit, shift left with zero fill.
REQ-029 SHIFT_HI exit: bit counter > 0 -> decrement, SHIFT_LO; else index > 0 -> decrement index, LOAD; else -> LATCH.
REQ-030 Word order: index NUM_DRIVERS-1 first, index 0 last; within a word, MSB first.
REQ-031 LATCH (1 cycle): latch=1, serial_clk=0; -> DONE.
REQ-032 DONE (1 cycle): done=1, busy=0 from the next cycle; -> IDLE.
REQ-033 Transfer length from first LOAD to LATCH exclusive: NUM_DRIVERS*(1+2*WIDTH) cycles.
REQ-034 All outputs registered; serial data and serial_clk are 0 outside SHIFT_LO/SHIFT_HI.
REQ-035 The three colour channels shift in lockstep; serial_clk is shared.
REQ-036 Simultaneous wr_en to the word being loaded in LOAD: the old value is loaded.

Reset
REQ-037 reset_n low -> immediately: state IDLE; serial_clk, serial data, latch, busy, done = 0; arrays = 0; brightness = all ones.
REQ-038 Reset asserted mid-transfer aborts it; no latch or done pulse is issued; start after reset release begins from index NUM_DRIVERS-1.

Verification
REQ-039 NUM_DRIVERS=2, WIDTH=16; red[1]=16'h1234, red[0]=16'haaaa, start mode 0 -> red stream 0001001000110100 then 1010101010101010; latch pulse 66 cycles after busy rises; done next cycle.
REQ-040 Defaults after reset, start mode 1 -> each colour emits 4x 16'h00ff; green/blue identical to red.
REQ-041 Mid-transfer write to red[0]=16'hffff while index 1 is shifting -> 16'hffff transmitted for word 0; write to red[1] at that time does not alter the current stream.
REQ-042 start pulsed during SHIFT -> ignored; exactly one latch and one done per accepted start.
REQ-043 reset_n low during SHIFT_HI -> all outputs 0 asynchronously; arrays cleared; no latch; new start runs a full-length transfer.
REQ-044 wr_color=3 or wr_addr=NUM_DRIVERS with wr_en -> no array change, checked by a subsequent transfer.
